pll_reset_sequencer: RTL and testbench

- Consumes the PLL's lock indication and produces the J1Sc system resets, clocked by the PLL output clock.
- Synchronizes and debounces the lock signal and an external reset button.
- Releases the peripheral reset first and the CPU core reset a fixed number of cycles later.
- Re-asserts both resets on lock loss or a button press, and counts lock-loss events for diagnostics.

---
 rtl/pll_reset_sequencer_pkg.sv | 13 +
 rtl/pll_reset_sequencer_sync_filter.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 73 +++++++
 tb/tb_pll_reset_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: sequencer state encoding and default cycle counts.
package pll_reset_sequencer_pkg;
   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      PERIPH    = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } seqState_t;
   localparam int DEF_LOCK_STABLE_CYCLES   = 1024;
   localparam int DEF_CORE_DELAY_CYCLES    = 16;
   localparam int DEF_BUTTON_FILTER_CYCLES = 4096;
   localparam int DEF_LOSS_CNT_WIDTH       = 8;
endpackage

// File: rtl/pll_reset_sequencer_sync_filter.sv
// pll_reset_sequencer_sync_filter: 2-flop synchronizer plus saturating stable-low detector.
module pll_reset_sequencer_sync_filter #(
   parameter int FILTER_CYCLES = 4096
) (
   input  logic clk,
   input  logic resetN,
   input  logic asyncIn,
   output logic lowStable
);
   localparam int CntW = $clog2(FILTER_CYCLES) < 1 ? 1 : $clog2(FILTER_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);
   logic meta, syncS;
   logic [CntW-1:0] lowCnt;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         meta   <= 1'b0;
         syncS  <= 1'b0;
         lowCnt <= '0;
      end else begin
         meta   <= asyncIn;
         syncS  <= meta;
         lowCnt <= syncS ? '0 : (lowCnt == CntMax ? lowCnt : lowCnt + 1'b1);
      end
   assign lowStable = lowCnt == CntMax;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns PLL lock and the reset button into staged peripheral/core resets.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
   parameter int CORE_DELAY_CYCLES    = DEF_CORE_DELAY_CYCLES,
   parameter int BUTTON_FILTER_CYCLES = DEF_BUTTON_FILTER_CYCLES,
   parameter int LOSS_CNT_WIDTH       = DEF_LOSS_CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      isLocked,
   input  logic                      extResetN,
   output logic                      periphResetN,
   output logic                      coreResetN,
   output logic                      sysReady,
   output logic [LOSS_CNT_WIDTH-1:0] lockLossCount
);
   localparam int CntW = $clog2(LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES ? LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES);
   localparam logic [CntW-1:0] StableMax = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] DelayMax  = CntW'(CORE_DELAY_CYCLES - 1);
   localparam logic [LOSS_CNT_WIDTH-1:0] LossMax = '1;
   seqState_t state, nextState;
   logic [CntW-1:0] cnt, cntNext;
   logic lockMeta, lockS, btnReq, lossEvent;
   pll_reset_sequencer_sync_filter #(.FILTER_CYCLES(BUTTON_FILTER_CYCLES)) u_btnFilter (
      .clk      (clk),
      .resetN   (resetN),
      .asyncIn  (extResetN),
      .lowStable(btnReq)
   );
   // One counter serves both the lock-stability wait and the core delay; it restarts on every state change.
   always_comb begin
      nextState = state;
      cntNext   = cnt;
      lossEvent = 1'b0;
      case (state)
         WAIT_LOCK: begin
            cntNext = !lockS ? '0 : (cnt == StableMax ? cnt : cnt + 1'b1);
            if (lockS && cnt == StableMax && !btnReq) nextState = PERIPH;
         end
         PERIPH, RUN: begin
            lossEvent = !lockS;
            cntNext   = state == PERIPH ? cnt + 1'b1 : cnt;
            if (!lockS || btnReq) nextState = LOST;
            else if (state == PERIPH && cnt == DelayMax) nextState = RUN;
         end
         default: nextState = WAIT_LOCK;
      endcase
      if (nextState != state) cntNext = '0;
   end
   // Outputs are decoded from the next state so they switch on the edge that enters each state.
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         lockMeta      <= 1'b0;
         lockS         <= 1'b0;
         state         <= WAIT_LOCK;
         cnt           <= '0;
         periphResetN  <= 1'b0;
         coreResetN    <= 1'b0;
         sysReady      <= 1'b0;
         lockLossCount <= '0;
      end else begin
         lockMeta     <= isLocked;
         lockS        <= lockMeta;
         state        <= nextState;
         cnt          <= cntNext;
         periphResetN <= nextState == PERIPH || nextState == RUN;
         coreResetN   <= nextState == RUN;
         sysReady     <= nextState == RUN;
         if (lossEvent && lockLossCount != LossMax) lockLossCount <= lockLossCount + 1'b1;
      end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed plan plus random lock/button stimulus against a timeline model.
module tb_pll_reset_sequencer;
   localparam int LS = 16, CD = 4, BF = 64, LW = 8, LOSS_MAX = 255;
   logic clk = 1'b0, resetN = 1'b0, isLocked = 1'b0, extResetN = 1'b1;
   logic periphResetN, coreResetN, sysReady;
   logic [LW-1:0] lockLossCount;
   int checks = 0, errors = 0;
   int lk0, lkS, bt0, btS, pressRun, phase, lockedRun, age, losses;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(LS), .CORE_DELAY_CYCLES(CD),
      .BUTTON_FILTER_CYCLES(BF), .LOSS_CNT_WIDTH(LW)
   ) dut (
      .clk(clk), .resetN(resetN), .isLocked(isLocked), .extResetN(extResetN),
      .periphResetN(periphResetN), .coreResetN(coreResetN),
      .sysReady(sysReady), .lockLossCount(lockLossCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // phase: 0 = held waiting for lock, 1 = released (age = edges since release), 2 = one-cycle loss pulse
   task automatic modelReset();
      lk0 = 0; lkS = 0; bt0 = 0; btS = 0;
      pressRun = 0; phase = 0; lockedRun = 0; age = 0; losses = 0;
   endtask

   task automatic modelStep();
      bit req;
      req = pressRun >= BF - 1;
      if (phase == 0) begin
         if (lkS != 0 && lockedRun >= LS - 1 && !req) begin
            phase = 1;
            age = 0;
         end else lockedRun = lkS != 0 ? lockedRun + 1 : 0;
      end else if (phase == 1) begin
         if (lkS == 0 || req) begin
            phase = 2;
            if (lkS == 0 && losses < LOSS_MAX) losses++;
         end else age++;
      end else begin
         phase = 0;
         lockedRun = 0;
      end
      pressRun = btS != 0 ? 0 : pressRun + 1;
      lkS = lk0; lk0 = int'(isLocked);
      btS = bt0; bt0 = int'(extResetN);
   endtask

   task automatic tick();
      logic [LW-1:0] expLoss;
      @(posedge clk);
      if (resetN) modelStep();
      #1;
      expLoss = losses[LW-1:0];
      check("outs", {periphResetN, coreResetN, sysReady, lockLossCount},
            {phase == 1, phase == 1 && age >= CD, phase == 1 && age >= CD, expLoss});
   endtask

   task automatic doReset();
      resetN = 1'b0;
      modelReset();
      repeat (3) tick();
      resetN = 1'b1;
   endtask

   task automatic waitReady();
      int n = 0;
      while (!sysReady && n < LS + CD + BF + 20) begin
         tick();
         n++;
      end
      check("ready", sysReady, 1);
   endtask

   task automatic dropLock();
      isLocked = 1'b0;
      repeat (3) tick();
      isLocked = 1'b1;
   endtask

   initial begin
      int n, lc0, lockHold, btnHold;
      bit seen;
      // 1: clean power-up sequence
      isLocked = 1'b1;
      doReset();
      check("rst_state", {periphResetN, coreResetN, sysReady, lockLossCount}, 0);
      n = 0;
      while (!periphResetN && n < LS + 20) begin
         tick();
         n++;
      end
      check("periph_latency_cycle", n + 1, 2 + LS + 1);
      check("core_held", coreResetN, 0);
      n = 0;
      while (!coreResetN && n < CD + 10) begin
         tick();
         n++;
      end
      check("core_delay", n, CD);
      check("ready_with_core", sysReady, 1);
      check("loss_zero", lockLossCount, 0);
      // 2: lock toggling faster than the stability window never releases
      isLocked = 1'b0;
      doReset();
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
         isLocked = ~isLocked;
         repeat (LS / 2) begin
            tick();
            seen |= periphResetN | coreResetN;
         end
      end
      check("toggle_no_release", seen, 0);
      check("toggle_no_loss", lockLossCount, 0);
      // 3: short lock drop while running
      isLocked = 1'b1;
      waitReady();
      dropLock();
      check("drop_resets", {periphResetN, coreResetN}, 0);
      check("drop_count", lockLossCount, 1);
      waitReady();
      // 4: bouncing button, then a steady press
      lc0 = lockLossCount;
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         extResetN = (i % 16 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         seen |= ~periphResetN | ~coreResetN;
      end
      check("bounce_no_reset", seen, 0);
      extResetN = 1'b1;
      repeat (3) tick();
      extResetN = 1'b0;
      n = 0;
      while (periphResetN && n < BF + 20) begin
         tick();
         n++;
      end
      check("press_latency", n, 2 + BF);
      seen = 1'b0;
      repeat (3 * BF) begin
         tick();
         seen |= periphResetN;
      end
      check("press_holds", seen, 0);
      extResetN = 1'b1;
      waitReady();
      check("press_no_count", lockLossCount, lc0);
      // 5: saturation, then asynchronous clear
      for (int e = 0; e < 300; e++) begin
         waitReady();
         dropLock();
      end
      check("loss_saturated", lockLossCount, LOSS_MAX);
      resetN = 1'b0;
      modelReset();
      #2;
      check("loss_async_clear", {lockLossCount, periphResetN}, 0);
      tick();
      resetN = 1'b1;
      // 6: lock loss and button request landing on the same edge
      waitReady();
      lc0 = lockLossCount;
      extResetN = 1'b0;
      repeat (BF - 1) tick();
      isLocked = 1'b0;
      repeat (3) tick();
      check("both_resets", {periphResetN, coreResetN}, 0);
      check("both_once", lockLossCount, lc0 + 1);
      tick();
      check("both_after_lost", lockLossCount, lc0 + 1);
      isLocked = 1'b1;
      extResetN = 1'b1;
      waitReady();
      // random lock/button activity
      lockHold = 0;
      btnHold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (lockHold == 0) begin
            isLocked = 1'($urandom_range(0, 3) != 0);
            lockHold = isLocked ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 6));
         end
         if (btnHold == 0) begin
            extResetN = 1'($urandom_range(0, 5) != 0);
            btnHold = extResetN ? int'($urandom_range(20, 300)) : int'($urandom_range(1, BF + 20));
         end
         lockHold--;
         btnHold--;
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
